// File: rtl/regfile_multi.sv
// Multi-port register file with argument load, display tap and clear sweep engine.
// Define REGFILE_WR_BYPASS_EN for write-first read/write collisions.
module regfile_multi #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int NRD      = 2,
  parameter int DISP_IDX = 10
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic [NRD*ADDR_W-1:0]   RA,
  output logic [NRD*DATA_W-1:0]   RD,
  input  logic [ADDR_W-1:0]       WA,
  input  logic                    RW,
  input  logic [DATA_W-1:0]       RWD,
  input  logic                    ARG_LD,
  input  logic [DATA_W-1:0]       ARGUMENT,
  input  logic                    CLR,
  output logic                    BUSY,
  output logic [DATA_W-1:0]       DISPLAY
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE,
    SWEEP
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DATA_W-1:0]     mem_d [DEPTH];
  logic [NRD*DATA_W-1:0] rd_q, rd_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    unique case (state_q)
      IDLE: begin
        if (RW) mem_d[WA] = RWD;
        // argument load has priority over a write to entry 0
        if (ARG_LD) mem_d[0] = ARGUMENT;
        if (CLR) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        mem_d[cnt_q] = '0;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_d = '0;
    for (int k = 0; k < NRD; k++) begin
      rd_d[k*DATA_W +: DATA_W] = mem_q[RA[k*ADDR_W +: ADDR_W]];
`ifdef REGFILE_WR_BYPASS_EN
      if (state_q == IDLE && RW && RA[k*ADDR_W +: ADDR_W] == WA)
        rd_d[k*DATA_W +: DATA_W] = RWD;
      if (state_q == IDLE && ARG_LD && RA[k*ADDR_W +: ADDR_W] == '0)
        rd_d[k*DATA_W +: DATA_W] = ARGUMENT;
`endif
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      mem_q   <= mem_d;
    end
  end

  assign RD      = rd_q;
  assign BUSY    = (state_q == SWEEP);
  assign DISPLAY = mem_q[DISP_IDX];

endmodule

// File: tb/tb_regfile_multi.sv
// Randomized self-checking bench for regfile_multi against a behavioural model.
module tb_regfile_multi;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [7:0]  RA;
  logic [31:0] RD;
  logic [3:0]  WA;
  logic        RW;
  logic [15:0] RWD;
  logic        ARG_LD;
  logic [15:0] ARGUMENT;
  logic        CLR;
  logic        BUSY;
  logic [15:0] DISPLAY;

  regfile_multi dut (
    .CLK(CLK), .RESET_N(RESET_N), .RA(RA), .RD(RD),
    .WA(WA), .RW(RW), .RWD(RWD), .ARG_LD(ARG_LD),
    .ARGUMENT(ARGUMENT), .CLR(CLR), .BUSY(BUSY), .DISPLAY(DISPLAY)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_pass = 0;

  logic [15:0] m_mem [16];
  logic [15:0] m_rd [2];
  bit          m_busy;
  int          m_left;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    m_rd[0] = '0;
    m_rd[1] = '0;
    m_busy  = 0;
    m_left  = 0;
  endtask

  // one clock edge of the register file's documented behaviour
  task automatic model_edge();
    logic [3:0]  a;
    logic [15:0] v;
    for (int k = 0; k < 2; k++) begin
      a = (k == 0) ? RA[3:0] : RA[7:4];
      v = m_mem[a];
`ifdef REGFILE_WR_BYPASS_EN
      if (!m_busy && RW && a == WA) v = RWD;
      if (!m_busy && ARG_LD && a == 4'd0) v = ARGUMENT;
`endif
      m_rd[k] = v;
    end
    if (m_busy) begin
      m_mem[16 - m_left] = '0;
      m_left--;
      if (m_left == 0) m_busy = 0;
    end else begin
      if (RW) m_mem[WA] = RWD;
      if (ARG_LD) m_mem[0] = ARGUMENT;
      if (CLR) begin
        m_busy = 1;
        m_left = 16;
      end
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge CLK);
    #1;
    chk("rd0", RD[15:0], m_rd[0]);
    chk("rd1", RD[31:16], m_rd[1]);
    chk("busy", BUSY, m_busy);
    chk("display", DISPLAY, m_mem[10]);
  endtask

  task automatic idle_in();
    RW = 0; ARG_LD = 0; CLR = 0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    RW = 1; WA = a; RWD = d;
    cycle();
    RW = 0;
  endtask

  task automatic read_all();
    for (int i = 0; i < 16; i += 2) begin
      RA = {4'(i + 1), 4'(i)};
      cycle();
    end
    RA = '0;
    cycle();
  endtask

  task automatic async_reset();
    #3;
    RESET_N = 0;
    #1;
    model_reset();
    chk("rst_rd", RD, 32'd0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_disp", DISPLAY, 16'd0);
    #2;
    RESET_N = 1;
  endtask

  initial begin
    int n;
    RESET_N = 0; RA = '0; WA = '0; RWD = '0; ARGUMENT = '0;
    idle_in();
    model_reset();
    #23;
    chk("init_rd", RD, 32'd0);
    chk("init_busy", BUSY, 1'b0);
    chk("init_disp", DISPLAY, 16'd0);
    RESET_N = 1;

    // reset with no clock edge needed
    wr(4'd5, 16'h1234);
    wr(4'd10, 16'h5555);
    RA = 8'h05;
    cycle();
    chk("pre_rst", RD[15:0], 16'h1234);
    async_reset();
    read_all();

    // write then read with display tap
    wr(4'd10, 16'hBEEF);
    chk("disp_wr", DISPLAY, 16'hBEEF);
    RA = 8'h0A;
    cycle();
    chk("rd_wr", RD[15:0], 16'hBEEF);

    // read/write collision
    wr(4'd3, 16'h0055);
    RA = 8'h30;
    RW = 1; WA = 4'd3; RWD = 16'h00AA;
    cycle();
    RW = 0;
`ifdef REGFILE_WR_BYPASS_EN
    chk("collide", RD[31:16], 16'h00AA);
`else
    chk("collide", RD[31:16], 16'h0055);
`endif

    // argument priority
    ARG_LD = 1; ARGUMENT = 16'h7777; RW = 1; WA = 4'd0; RWD = 16'h1111;
    cycle();
    idle_in();
    RA = 8'h00;
    cycle();
    chk("arg_pri", RD[15:0], 16'h7777);
    ARG_LD = 1; RW = 1; WA = 4'd4;
    cycle();
    idle_in();
    RA = 8'h40;
    cycle();
    chk("arg_e0", RD[15:0], 16'h7777);
    chk("arg_e4", RD[31:16], 16'h1111);

    // full sweep with a dropped write
    for (int i = 0; i < 16; i++) wr(4'(i), 16'hFFFF);
    CLR = 1;
    cycle();
    CLR = 0;
    n = 0;
    while (BUSY && n < 40) begin
      n++;
      if (n == 5) begin
        RW = 1; WA = 4'd2; RWD = 16'h1234;
      end
      cycle();
      RW = 0;
    end
    chk("sweep_len", n, 16);
    wr(4'd7, 16'hABCD);
    read_all();
    RA = 8'h27;
    cycle();
    chk("after_e7", RD[15:0], 16'hABCD);
    chk("after_e2", RD[31:16], 16'h0000);

    // reset mid-sweep, then restart
    for (int i = 0; i < 16; i++) wr(4'(i), 16'h0F0F);
    CLR = 1;
    cycle();
    CLR = 0;
    for (int i = 0; i < 7; i++) cycle();
    async_reset();
    CLR = 1;
    cycle();
    CLR = 0;
    n = 0;
    while (BUSY && n < 40) begin
      n++;
      cycle();
    end
    chk("resweep_len", n, 16);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      RA       = 8'($urandom);
      WA       = 4'($urandom);
      RWD      = 16'($urandom);
      ARGUMENT = 16'($urandom);
      RW       = ($urandom_range(0, 1) == 1);
      ARG_LD   = ($urandom_range(0, 3) == 0);
      CLR      = ($urandom_range(0, 29) == 0);
      cycle();
    end
    idle_in();
    for (int i = 0; i < 18; i++) cycle();
    read_all();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_multi.md
Name: regfile_multi

Overview:
- Parametrised successor to the CPU's 16x16 register file.
- Provides NRD registered read ports and one synchronous write port.
- Provides a dedicated argument-load path into register 0 and a combinational display tap.
- Adds a hardware clear engine that zeros every entry, one entry per cycle, while signalling busy; the datapath and control sequencer sit around it.

Parameters:
- DATA_W, 16, width of each register in bits.
- ADDR_W, 4, address width; depth DEPTH = 2**ADDR_W.
- NRD, 2, number of read ports (1..4).
- DISP_IDX, 10, index of the register driven onto DISPLAY (0..DEPTH-1).

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- RA  in  NRD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- RD  out  NRD*DATA_W  packed registered read data; port k uses bits [k*DATA_W +: DATA_W].
- WA  in  ADDR_W  write address.
- RW  in  1  write enable.
- RWD  in  DATA_W  write data.
- ARG_LD  in  1  load ARGUMENT into register 0.
- ARGUMENT  in  DATA_W  argument value.
- CLR  in  1  start clear sweep (single-cycle pulse sampled in IDLE).
- BUSY  out  1  high while clear sweep is in progress.
- DISPLAY  out  DATA_W  combinational copy of entry DISP_IDX.

Behaviour:
- Reset: RESET_N low asynchronously forces:
  - all DEPTH entries to 0;
  - all RD ports to 0;
  - FSM to IDLE, sweep counter to 0, BUSY to 0.
  - DISPLAY therefore reads 0.
  - Reset deassertion is used synchronously; the first active edge is the first edge with RESET_N high.
- Reads:
  - Every edge, RD[k] <= entry[RA[k]], independent of FSM state.
  - Latency is 1 cycle; no read enable.
- Read/write collision: a read of an entry being written on the same edge returns the old value (read-first), unless WR_BYPASS_EN is defined (see Optional Feature).
- Writes, IDLE only:
  - RW=1 writes RWD to entry[WA] at the edge.
  - ARG_LD=1 writes ARGUMENT to entry[0].
  - If both target entry 0, ARGUMENT wins.
  - If WA != 0, both writes occur on the same edge.
- FSM states IDLE and SWEEP:
  - IDLE -> SWEEP on CLR=1. On that edge counter <= 0 and BUSY <= 1; the RW/ARG_LD writes on that edge are still performed.
  - SWEEP: each edge, entry[counter] <= 0 and counter <= counter+1.
  - When counter == DEPTH-1, that entry is zeroed, the FSM returns to IDLE, BUSY <= 0 and counter <= 0.
  - Sweep occupies exactly DEPTH cycles of BUSY=1. The first normal write is accepted on the edge after BUSY falls.
  - In SWEEP, RW, ARG_LD and CLR are ignored (dropped, not queued). Reads continue and may return partially cleared contents.
- Counter is ADDR_W bits; the terminal compare is explicit, with no reliance on wrap.
- RESET_N low mid-sweep aborts immediately: everything goes to the reset state.
- DISPLAY follows entry[DISP_IDX] combinationally; it changes the cycle the entry is written.
- RA/WA are full-range; no out-of-range case exists.

Optional Feature:
- Macro: REGFILE_WR_BYPASS_EN.
- Defined: write-first collision behaviour.
  - If RW=1 in IDLE and RA[k]==WA, RD[k] captures RWD on that edge.
  - If ARG_LD=1 and RA[k]==0, RD[k] captures ARGUMENT; ARGUMENT wins if both apply.
  - No bypass during SWEEP: zeroed entries read old data for one cycle.
- Undefined: read-first; RD[k] captures the pre-edge entry contents.

Test Plan:
1. Reset: write entry5=0x1234, pulse RESET_N low mid-cycle -> RD, DISPLAY and all entries read 0 immediately, with no clock needed.
2. Write/read: RW=1, WA=10, RWD=0xBEEF -> DISPLAY=0xBEEF after that edge. RA0=10 on the next cycle -> RD0=0xBEEF one edge later.
3. Collision: RW=1, WA=3, RWD=0x00AA with RA1=3 on the same edge, entry3 previously 0x0055 -> RD1=0x0055 without the macro, 0x00AA with REGFILE_WR_BYPASS_EN.
4. Arg priority: ARG_LD=1, ARGUMENT=0x7777, RW=1, WA=0, RWD=0x1111 -> entry0=0x7777. Repeat with WA=4 -> entry0=0x7777 and entry4=0x1111.
5. Sweep: fill all entries with 0xFFFF, pulse CLR -> BUSY high for exactly 16 cycles, RW to entry2 at cycle 5 is dropped, all entries 0 afterwards. A write on the edge after BUSY falls is accepted.
6. Reset mid-sweep: assert RESET_N low at sweep cycle 7 -> BUSY=0 at once and FSM in IDLE. After release, CLR restarts the sweep at counter 0.
